// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default bus widths and
// the arbitration FSM encoding.
package ram_arb_pkg;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int DATA_W_DEFAULT = 32;

  // IDLE arbitrates round-robin; LOCKn reserves the RAM for port n.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage : ram_arb_pkg

// File: rtl/ram_rr_pick.sv
// Combinational winner selection for the two-port RAM arbiter.
// In IDLE the port not granted most recently wins a contention; in LOCKn
// only port n can be granted.
module ram_rr_pick
  import ram_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  input  arb_state_e state,
  output logic       gnt0,
  output logic       gnt1
);

  // Pick at most one port from the live requests and the arbitration state
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          // last_gnt holds the index of the previous winner
          if (last_gnt) begin
            gnt0 = 1'b1;
          end else begin
            gnt1 = 1'b1;
          end
        end else if (req0) begin
          gnt0 = 1'b1;
        end else if (req1) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      end
      LOCK0: begin
        gnt0 = req0;
      end
      LOCK1: begin
        gnt1 = req1;
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

endmodule : ram_rr_pick

// File: rtl/ram_arbiter2.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Grants are combinational so a command reaches the RAM on the same edge it
// is accepted; read data comes back from the RAM one cycle later and is
// flagged to the owning port through a registered rvalid.
module ram_arbiter2
  import ram_arb_pkg::*;
#(
  parameter int AddressWidth = ADDR_W_DEFAULT,
  parameter int DataWidth    = DATA_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    wr0,
  input  logic                    wr1,
  input  logic [AddressWidth-1:0] addr0,
  input  logic [AddressWidth-1:0] addr1,
  input  logic [DataWidth-1:0]    wdata0,
  input  logic [DataWidth-1:0]    wdata1,
  input  logic                    lock0,
  input  logic                    lock1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [DataWidth-1:0]    rdata,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [AddressWidth-1:0] ram_addr,
  output logic [DataWidth-1:0]    ram_din,
  input  logic [DataWidth-1:0]    ram_dout
);

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  logic       last_gnt_r;
  logic       pick_gnt0_s;
  logic       pick_gnt1_s;
  logic       gnt0_s;
  logic       gnt1_s;
  // rvalidN_r doubles as the pending read-owner record: it marks which port
  // issued the read whose data the RAM presents this cycle.
  logic       rvalid0_r;
  logic       rvalid1_r;

  ram_rr_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_r),
    .state    (state_r),
    .gnt0     (pick_gnt0_s),
    .gnt1     (pick_gnt1_s)
  );

  // Grants are forced off while reset is held so no RAM access can start
  assign gnt0_s = pick_gnt0_s & rst_n;
  assign gnt1_s = pick_gnt1_s & rst_n;

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign rvalid0 = rvalid0_r;
  assign rvalid1 = rvalid1_r;
  assign rdata   = ram_dout;
  assign ram_en  = ~(gnt0_s | gnt1_s);

  // Route the granted port's command onto the RAM port; park it when idle
  always_comb begin
    ram_we   = 1'b1;
    ram_addr = {AddressWidth{1'b0}};
    ram_din  = {DataWidth{1'b0}};
    if (gnt0_s) begin
      ram_we   = ~wr0;
      ram_addr = addr0;
      ram_din  = wdata0;
    end else if (gnt1_s) begin
      ram_we   = ~wr1;
      ram_addr = addr1;
      ram_din  = wdata1;
    end else begin
      ram_we   = 1'b1;
      ram_addr = {AddressWidth{1'b0}};
      ram_din  = {DataWidth{1'b0}};
    end
  end

  // Lock entry on a locked grant from IDLE; release when the owner drops lock
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt0_s && lock0) begin
          state_nxt_s = LOCK0;
        end else if (gnt1_s && lock1) begin
          state_nxt_s = LOCK1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK0: begin
        if (!lock0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCK0;
        end
      end
      LOCK1: begin
        if (!lock1) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCK1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin pointer: remembers the port granted most recently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_r <= 1'b1;
    end else if (gnt0_s) begin
      last_gnt_r <= 1'b0;
    end else if (gnt1_s) begin
      last_gnt_r <= 1'b1;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

  // Flag the owner of a read issued this cycle; its data arrives next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      rvalid0_r <= gnt0_s & ~wr0;
      rvalid1_r <= gnt1_s & ~wr1;
    end
  end

endmodule : ram_arbiter2

// File: tb/tb_ram_arbiter2.sv
// Self-checking bench for ram_arbiter2 with a behavioural synchronous RAM.
// Read expectations go into a scoreboard when the read is granted; observed
// rvalid events are collected by a monitor and matched at the end.
module tb_ram_arbiter2;
  import ram_arb_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, wr0, wr1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t obs_ev;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] mem     [0:63];
  logic [DW-1:0] exp_mem [0:63];
  logic          init_done = 1'b0;

  ram_arbiter2 #(.AddressWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] pat(input int a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expectations and observations
  always @(posedge clk) cyc <= cyc + 1;

  // External RAM: synchronous, enable active-low, ram_we=1 means read
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
      init_done <= 1'b1;
    end else if (!ram_en) begin
      if (!ram_we) mem[ram_addr] <= ram_din;
      else         ram_dout <= mem[ram_addr];
    end
  end

  // Monitor: record every rvalid event (port 2 marks both asserted)
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      obs_ev.cyc  = cyc;
      obs_ev.port = (rvalid0 && rvalid1) ? 2 : (rvalid1 ? 1 : 0);
      obs_ev.data = rdata;
      obs_q.push_back(obs_ev);
    end
  end

  task automatic set_idle();
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic push_read(input int port, input int addr);
    ev_t e;
    e.cyc  = cyc + 1;
    e.port = port;
    e.data = exp_mem[addr];
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 6'd9; wdata0 = 32'hBAD0_BAD0;
    req1 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, ram_en, rvalid0, rvalid1} !== 5'b00100) begin
        failures++;
        $display("FAIL reset_outputs: got gnt=%b%b en=%b rv=%b%b want gnt=00 en=1 rv=00",
                 gnt0, gnt1, ram_en, rvalid0, rvalid1);
      end
    end
    @(posedge clk); #1;
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b1 ||
          ram_addr !== 6'd0 || ram_din !== 32'd0) begin
        failures++;
        $display("FAIL idle_port: got gnt=%b%b en=%b we=%b addr=%0d din=%h want 00 1 1 0 0",
                 gnt0, gnt1, ram_en, ram_we, ram_addr, ram_din);
      end
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 6'd5; wdata0 = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0 ||
        ram_addr !== 6'd5 || ram_din !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_cmd: got gnt=%b%b en=%b we=%b addr=%0d din=%h want 10 0 0 5 deadbeef",
               gnt0, gnt1, ram_en, ram_we, ram_addr, ram_din);
    end
    exp_mem[5] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    wr0 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || ram_en !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 6'd5 ||
        rvalid0 !== 1'b0) begin
      failures++;
      $display("FAIL rd_cmd: got gnt0=%b en=%b we=%b addr=%0d rv0=%b want 1 0 1 5 0",
               gnt0, ram_en, ram_we, ram_addr, rvalid0);
    end
    push_read(0, 5);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd_data: got rv=%b%b rdata=%h want rv=10 rdata=deadbeef",
               rvalid0, rvalid1, rdata);
    end
  endtask

  task automatic test_lock();
    // Port 0 was granted last, so port 1 wins the opening contention
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 6'd7;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 6'd3; lock1 = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || ram_addr !== 6'd3 || ram_we !== 1'b1) begin
      failures++;
      $display("FAIL lock_first: got gnt=%b%b addr=%0d we=%b want 01 3 1",
               gnt0, gnt1, ram_addr, ram_we);
    end
    push_read(1, 3);
    // Second locked read: port 0 keeps waiting
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dut.state_r !== LOCK1 || gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
      failures++;
      $display("FAIL lock_hold: got state=%0d gnt=%b%b want state=%0d gnt=01",
               dut.state_r, gnt0, gnt1, LOCK1);
    end
    push_read(1, 3);
    // Final locked command is the write, issued with lock1 dropped
    @(posedge clk); #1;
    wr1 = 1'b1; wdata1 = 32'h1234_5678; lock1 = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_r !== LOCK1 || gnt0 !== 1'b0 || gnt1 !== 1'b1 || ram_we !== 1'b0 ||
        ram_din !== 32'h1234_5678) begin
      failures++;
      $display("FAIL lock_write: got state=%0d gnt=%b%b we=%b din=%h want %0d 01 0 12345678",
               dut.state_r, gnt0, gnt1, ram_we, ram_din, LOCK1);
    end
    exp_mem[3] = 32'h1234_5678;
    @(posedge clk); #1;
    req1 = 1'b0; wr1 = 1'b0; wdata1 = '0;
    @(negedge clk);
    checks++;
    if (dut.state_r !== IDLE || gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_addr !== 6'd7) begin
      failures++;
      $display("FAIL lock_release: got state=%0d gnt=%b%b addr=%0d want %0d 10 7",
               dut.state_r, gnt0, gnt1, ram_addr, IDLE);
    end
    push_read(0, 7);
    // Read back the locked write from port 1
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b1; addr1 = 6'd3;
    @(negedge clk);
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL lock_readback: got gnt=%b%b want 01", gnt0, gnt1);
    end
    push_read(1, 3);
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_round_robin();
    int win [4] = '{0, 1, 0, 1};
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0 = 1'b1; addr0 = 6'd1;
    req1 = 1'b1; addr1 = 6'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== (win[i] == 0) || gnt1 !== (win[i] == 1) ||
          ram_addr !== ((win[i] == 0) ? 6'd1 : 6'd2)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got gnt=%b%b addr=%0d want port %0d",
                 i, gnt0, gnt1, ram_addr, win[i]);
      end
      push_read(win[i], (win[i] == 0) ? 1 : 2);
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_mid_reset();
    // Locked read by port 0; its rvalid must be killed by the reset pulse
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 6'd5; lock0 = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_grant: got gnt=%b%b want 10", gnt0, gnt1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 6'd4;
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1, gnt0, gnt1, ram_en} !== 5'b00001) begin
      failures++;
      $display("FAIL mid_reset: got rv=%b%b gnt=%b%b en=%b want rv=00 gnt=00 en=1",
               rvalid0, rvalid1, gnt0, gnt1, ram_en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    lock0 = 1'b0; addr0 = 6'd1;
    wr1 = 1'b0; addr1 = 6'd2;
    @(negedge clk);
    checks++;
    if (dut.state_r !== IDLE || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_pick: got state=%0d gnt=%b%b want %0d 10",
               dut.state_r, gnt0, gnt1, IDLE);
    end
    push_read(0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_rr: got gnt=%b%b want 01", gnt0, gnt1);
    end
    push_read(1, 2);
    @(posedge clk); #1;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_scoreboard();
    ev_t o;
    ev_t e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got rvalid port %0d cyc %0d data %h want none",
                 o.port, o.cyc, o.data);
      end else begin
        e = exp_q.pop_front();
        if (o.cyc !== e.cyc || o.port !== e.port || o.data !== e.data) begin
          failures++;
          $display("FAIL sb_read: got port %0d cyc %0d data %h want port %0d cyc %0d data %h",
                   o.port, o.cyc, o.data, e.port, e.cyc, e.data);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL sb_missing: got no rvalid want port %0d cyc %0d data %h",
               e.port, e.cyc, e.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) exp_mem[i] = pat(i);
    test_reset();
    test_idle();
    test_write_read();
    test_lock();
    test_round_robin();
    test_mid_reset();
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_arbiter2

// File: doc/ram_arbiter2.md
RAM_ARBITER2 -- requirements
Module: ram_arbiter2

Interface
REQ-001 SHALL have parameter AddressWidth, default 6, RAM word address width.
REQ-002 SHALL have parameter DataWidth, default 32, RAM word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have ports req0/req1  input  1  access request from port 0/1, active-high.
REQ-006 SHALL have ports wr0/wr1  input  1  per-port access type, 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  AddressWidth  per-port word address.
REQ-008 SHALL have ports wdata0/wdata1  input  DataWidth  per-port write data.
REQ-009 SHALL have ports lock0/lock1  input  1  per-port request to hold ownership after the current grant.
REQ-010 SHALL have ports gnt0/gnt1  output  1  access accepted this cycle; combinational.
REQ-011 SHALL have ports rvalid0/rvalid1  output  1  read data valid for port 0/1; registered.
REQ-012 SHALL have port rdata  output  DataWidth  read data, shared by both ports; equal to ram_dout.
REQ-013 SHALL have port ram_en  output  1  RAM enable, active-low.
REQ-014 SHALL have port ram_we  output  1  RAM direction, 1 = read, 0 = write.
REQ-015 SHALL have ports ram_addr  output  AddressWidth,  ram_din  output  DataWidth, and  ram_dout  input  DataWidth.

Function
REQ-016 SHALL assert at most one grant per cycle; gntN = 1 means that port's command is issued to the RAM on this clock edge.
REQ-017 SHALL drive ram_en=0 exactly when a grant is given; ram_we = ~wrN; ram_addr = addrN; ram_din = wdataN of the granted port.
REQ-018 SHALL, when no grant is given, drive ram_en=1, ram_we=1, ram_addr=0, ram_din=0.
REQ-019 SHALL keep reqN, wrN, addrN, wdataN and lockN stable from assertion of reqN until gntN; a port may deassert reqN only after its grant.
REQ-020 SHALL assert rvalidN for exactly one cycle, in the cycle after a granted read by port N; rdata is valid only in that cycle.
REQ-021 SHALL produce no rvalid for writes; back-to-back reads SHALL give one rvalid per cycle, in grant order.
REQ-022 SHALL implement FSM states IDLE, LOCK0, LOCK1.
REQ-023 In IDLE with one request: that port is granted. With both: the port not granted most recently is granted (round-robin pointer last_gnt).
REQ-024 In IDLE, a grant to port N with lockN=1 SHALL move the FSM to LOCKN on that edge.
REQ-025 In LOCKN only port N SHALL be granted; requests from the other port SHALL wait, ungranted.
REQ-026 In LOCKN, lockN=0 sampled at an edge SHALL return the FSM to IDLE; the other port becomes eligible the following cycle.
REQ-027 SHALL update last_gnt on every grant, including grants issued in LOCKN.
REQ-028 A lock SHALL be held indefinitely while lockN=1; no timeout.
REQ-029 SHALL require no address or data arithmetic; all buses pass through unmodified at full width.

Reset
REQ-030 While rst_n=0: FSM=IDLE, last_gnt=1 (port 0 wins first contention), rvalid0=rvalid1=0, and the pending read-owner register is cleared.
REQ-031 While rst_n=0, gnt0=gnt1=0 and ram_en=1, independent of requests.
REQ-032 An assertion of rst_n mid-operation SHALL drop any pending rvalid and release any lock; no RAM write SHALL be issued during reset.

Structure
REQ-033 FSM state encoding and the AddressWidth/DataWidth defaults SHALL live in shared package ram_arb_pkg.
REQ-034 Round-robin selection SHALL be a combinational sub-module ram_rr_pick (inputs req0, req1, last_gnt, state; outputs gnt0, gnt1).
REQ-035 The RAM itself SHALL be external; the block SHALL only drive its port.

Verification
REQ-036 Port 0 writes 0xDEADBEEF to address 5, then reads address 5 -> gnt0 in both cycles; rvalid0=1 with rdata=0xDEADBEEF one cycle after the read grant.
REQ-037 After reset, req0 and req1 both held as reads of 1 and 2 -> grants in the order 0,1,0,1; rvalid follows each read grant by one cycle on the matching port.
REQ-038 Port 1 lock1=1 read addr 3 then write addr 3, with req0 held throughout -> gnt0=0 until the cycle after lock1 falls; the FSM visits LOCK1 and then IDLE.
REQ-039 Idle with no requests -> ram_en=1, ram_addr=0, gnt0=gnt1=0 every cycle.
REQ-040 rst_n pulsed low in the cycle after a granted read -> rvalid stays 0; the FSM is IDLE and the next contention is granted to port 0.
